// File: rtl/dtw_engine_sat.sv
// Subsequence DTW engine: loads a reference into local memory, then scores each
// query from the source FIFO with a saturating cost row buffer and reports the best match.
module dtw_engine_sat #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned REF_DEPTH = 32768,
  parameter int unsigned ADDR_W    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_mode,
  input  logic [31:0]       ref_len,
  input  logic [15:0]       qry_len,
  input  logic              abort,
  output logic              busy,
  output logic              error,
  output logic              ref_valid,
  output logic              src_fifo_rden,
  input  logic              src_fifo_empty,
  input  logic [31:0]       src_fifo_data,
  output logic              sink_valid,
  input  logic              sink_ready,
  output logic [ACC_W-1:0]  sink_minval,
  output logic [31:0]       sink_position,
  output logic [31:0]       sink_qid
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned SUM_W = ((ACC_W > DATA_W + 1) ? ACC_W : DATA_W + 1) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [2:0] {IDLE, REF_LOAD, Q_ID, Q_SAMPLE, Q_SWEEP, Q_DONE} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0] ref_mem [REF_DEPTH];
  logic [ACC_W-1:0]  row_mem [REF_DEPTH];

  logic [LEN_W-1:0]  wptr, len_l, rd_j, p_j;
  logic [15:0]       qlen_l, i;
  logic [DATA_W-1:0] q_s, ref_q;
  logic [ACC_W-1:0]  row_q, diag, left;
  logic              p_vld;
  logic              busy_d, rden_d, sink_valid_d;

  logic take_c, load_ok_c, qry_ok_c, start_bad_c, load_end_c, row_end_c, last_row_c;
  logic [DATA_W:0]   diff_c, cost_c;
  logic [ACC_W-1:0]  diag_e_c, left_e_c, min_c, cell_c;
  logic [SUM_W-1:0]  sum_c;

  assign take_c      = src_fifo_rden & ~src_fifo_empty;
  assign load_ok_c   = (state == IDLE) && start && op_mode &&
                       (ref_len != 32'd0) && (ref_len <= 32'(REF_DEPTH));
  assign qry_ok_c    = (state == IDLE) && start && !op_mode && ref_valid && (qry_len != 16'd0);
  assign start_bad_c = (state == IDLE) && start && !load_ok_c && !qry_ok_c;
  assign load_end_c  = take_c && (wptr == len_l - LEN_W'(1));
  assign row_end_c   = p_vld && (p_j == len_l - LEN_W'(1));
  assign last_row_c  = (i == qlen_l - 16'd1);

  // Cell cost: |q - r| plus the cheapest predecessor, saturating at all-ones
  always_comb begin
    diff_c   = {q_s[DATA_W-1], q_s} - {ref_q[DATA_W-1], ref_q};
    cost_c   = diff_c[DATA_W] ? (~diff_c + (DATA_W+1)'(1)) : diff_c;
    diag_e_c = (p_j == '0) ? ACC_MAX : diag;
    left_e_c = (p_j == '0) ? ACC_MAX : left;
    min_c    = row_q;
    if (diag_e_c < min_c) min_c = diag_e_c;
    if (left_e_c < min_c) min_c = left_e_c;
    if (i == 16'd0) min_c = '0;
    sum_c    = SUM_W'(cost_c) + SUM_W'(min_c);
    cell_c   = (sum_c > SUM_W'(ACC_MAX)) ? ACC_MAX : sum_c[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (load_ok_c) state_nx = REF_LOAD;
                else if (qry_ok_c) state_nx = Q_ID;
      REF_LOAD: if (abort) state_nx = IDLE;
                else if (load_end_c) state_nx = IDLE;
      Q_ID:     if (abort) state_nx = IDLE;
                else if (take_c) state_nx = Q_SAMPLE;
      Q_SAMPLE: if (abort) state_nx = IDLE;
                else if (take_c) state_nx = Q_SWEEP;
      Q_SWEEP:  if (abort) state_nx = IDLE;
                else if (row_end_c) state_nx = last_row_c ? Q_DONE : Q_SAMPLE;
      Q_DONE:   if (sink_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_d       = (state_nx != IDLE);
    rden_d       = (state_nx == REF_LOAD) || (state_nx == Q_ID) || (state_nx == Q_SAMPLE);
    sink_valid_d = (state_nx == Q_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy          <= 1'b0;
      src_fifo_rden <= 1'b0;
      sink_valid    <= 1'b0;
    end else begin
      busy          <= busy_d;
      src_fifo_rden <= rden_d;
      sink_valid    <= sink_valid_d;
    end
  end

  // Control registers, sweep pipeline and last-row minimum tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      error         <= 1'b0;
      ref_valid     <= 1'b0;
      wptr          <= '0;
      len_l         <= '0;
      qlen_l        <= '0;
      i             <= '0;
      q_s           <= '0;
      rd_j          <= '0;
      p_vld         <= 1'b0;
      p_j           <= '0;
      diag          <= '1;
      left          <= '1;
      sink_minval   <= '0;
      sink_position <= '0;
      sink_qid      <= '0;
    end else begin
      if (start_bad_c) error <= 1'b1;
      else if (load_ok_c || qry_ok_c) error <= 1'b0;
      if (load_ok_c) begin
        ref_valid <= 1'b0;
        len_l     <= LEN_W'(ref_len);
        wptr      <= '0;
      end
      if (qry_ok_c) qlen_l <= qry_len;
      if (state == REF_LOAD && take_c && !abort) begin
        wptr <= wptr + LEN_W'(1);
        if (load_end_c) ref_valid <= 1'b1;
      end
      if (state == Q_ID && take_c) begin
        sink_qid <= src_fifo_data;
        i        <= '0;
      end
      if (state == Q_SAMPLE && take_c) begin
        q_s   <= src_fifo_data[DATA_W-1:0];
        rd_j  <= '0;
        p_vld <= 1'b0;
      end
      if (state == Q_SWEEP) begin
        p_vld <= (rd_j < len_l);
        p_j   <= rd_j;
        if (rd_j < len_l) rd_j <= rd_j + LEN_W'(1);
        if (p_vld) begin
          diag <= row_q;
          left <= cell_c;
          if (last_row_c && ((p_j == '0) || (cell_c < sink_minval))) begin
            sink_minval   <= cell_c;
            sink_position <= 32'(p_j);
          end
        end
        if (row_end_c && !last_row_c) i <= i + 16'd1;
      end
    end
  end

  // Synchronous-read memories; sweep reads j+1 while writing j, so no collision
  always_ff @(posedge clk) begin
    if (state == REF_LOAD && take_c) ref_mem[wptr[ADDR_W-1:0]] <= src_fifo_data[DATA_W-1:0];
    ref_q <= ref_mem[rd_j[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (state == Q_SWEEP && p_vld) row_mem[p_j[ADDR_W-1:0]] <= cell_c;
    row_q <= row_mem[rd_j[ADDR_W-1:0]];
  end

endmodule

// File: tb/tb_dtw_engine_sat.sv
// Bench for dtw_engine_sat: FIFO model feeding directed loads/queries, scoreboard-checked results.
module tb_dtw_engine_sat;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op_mode = 1'b0;
  logic [31:0] ref_len = '0;
  logic [15:0] qry_len = '0;
  logic        abort = 1'b0;
  logic        busy, error, ref_valid, src_fifo_rden, sink_valid;
  logic        src_fifo_empty = 1'b1;
  logic [31:0] src_fifo_data = '0;
  logic        sink_ready = 1'b1;
  logic [15:0] sink_minval;
  logic [31:0] sink_position, sink_qid;

  typedef struct {
    logic [15:0] minval;
    logic [31:0] pos;
    logic [31:0] qid;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] fifo_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  dtw_engine_sat #(.DATA_W(16), .ACC_W(16), .REF_DEPTH(64), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op_mode(op_mode), .ref_len(ref_len),
    .qry_len(qry_len), .abort(abort), .busy(busy), .error(error), .ref_valid(ref_valid),
    .src_fifo_rden(src_fifo_rden), .src_fifo_empty(src_fifo_empty),
    .src_fifo_data(src_fifo_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .sink_minval(sink_minval), .sink_position(sink_position), .sink_qid(sink_qid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // First-word-fall-through FIFO model
  always @(posedge clk) begin
    if (src_fifo_rden && !src_fifo_empty && fifo_q.size() > 0) void'(fifo_q.pop_front());
  end
  always @(negedge clk) begin
    src_fifo_empty = (fifo_q.size() == 0);
    src_fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
  end

  // Monitor: every presented result must match the scoreboard head
  always @(negedge clk) begin
    if (!rst && sink_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got qid %h expected none", sink_qid);
      end else begin
        check("sink_minval", 32'(sink_minval), 32'(sb[0].minval));
        check("sink_position", sink_position, sb[0].pos);
        check("sink_qid", sink_qid, sb[0].qid);
        if (sink_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic do_start(input logic op, input logic [31:0] rl, input logic [15:0] ql);
    @(posedge clk); #1;
    start = 1'b1; op_mode = op; ref_len = rl; qry_len = ql;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_abort();
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int max);
    bit done = 1'b0;
    for (int k = 0; k < max && !done; k++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout: busy=%0b pending=%0d expected idle", name, busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic query(input logic [31:0] qid, input logic [15:0] ql, input logic [31:0] s0,
                       input logic [31:0] s1, input logic [15:0] mv, input logic [31:0] pos);
    fifo_q.push_back(qid);
    fifo_q.push_back(s0);
    if (ql > 16'd1) fifo_q.push_back(s1);
    sb.push_back('{minval: mv, pos: pos, qid: qid});
    do_start(1'b0, 32'd0, ql);
    wait_idle("query", 200);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_ref_valid", 32'(ref_valid), 32'd0);
    check("rst_rden", 32'(src_fifo_rden), 32'd0);
    check("rst_sink_valid", 32'(sink_valid), 32'd0);
    check("rst_minval", 32'(sink_minval), 32'd0);
    check("rst_position", sink_position, 32'd0);
    check("rst_qid", sink_qid, 32'd0);

    // Error cases
    do_start(1'b0, 32'd0, 16'd1);
    check("qry_noref_error", 32'(error), 32'd1);
    check("qry_noref_busy", 32'(busy), 32'd0);
    do_start(1'b1, 32'd0, 16'd0);
    check("load_len0_error", 32'(error), 32'd1);
    check("load_len0_busy", 32'(busy), 32'd0);
    do_start(1'b1, 32'd65, 16'd0);
    check("load_toolong_error", 32'(error), 32'd1);

    // Abort a load after 3 of 5 words
    fifo_q.push_back(32'd1); fifo_q.push_back(32'd5); fifo_q.push_back(32'd3);
    do_start(1'b1, 32'd5, 16'd0);
    check("valid_start_clears_error", 32'(error), 32'd0);
    repeat (8) @(negedge clk);
    check("load_stall_busy", 32'(busy), 32'd1);
    check("load_stall_fifo_drained", 32'(fifo_q.size()), 32'd0);
    do_abort();
    check("abort_load_busy", 32'(busy), 32'd0);
    check("abort_load_ref_valid", 32'(ref_valid), 32'd0);
    check("abort_load_rden", 32'(src_fifo_rden), 32'd0);

    // Load reference [1,5,3,7,2]
    fifo_q.push_back(32'd1); fifo_q.push_back(32'd5); fifo_q.push_back(32'd3);
    fifo_q.push_back(32'd7); fifo_q.push_back(32'd2);
    do_start(1'b1, 32'd5, 16'd0);
    wait_idle("load", 50);
    check("load_ref_valid", 32'(ref_valid), 32'd1);

    query(32'hA5, 16'd2, 32'd5, 32'd3, 16'd0, 32'd2);
    query(32'h11, 16'd1, 32'd7, 32'd0, 16'd0, 32'd3);
    query(32'h12, 16'd1, 32'd4, 32'd0, 16'd1, 32'd1);

    // Sink backpressure for 20 cycles
    sink_ready = 1'b0;
    fifo_q.push_back(32'h13); fifo_q.push_back(32'd7);
    sb.push_back('{minval: 16'd0, pos: 32'd3, qid: 32'h13});
    do_start(1'b0, 32'd0, 16'd1);
    for (int k = 0; k < 100 && !sink_valid; k++) @(negedge clk);
    check("hold_valid_seen", 32'(sink_valid), 32'd1);
    repeat (20) @(negedge clk);
    check("hold_valid_stays", 32'(sink_valid), 32'd1);
    @(posedge clk); #1 sink_ready = 1'b1;
    wait_idle("hold", 20);
    repeat (5) @(negedge clk);
    check("hold_busy_after", 32'(busy), 32'd0);
    check("hold_valid_after", 32'(sink_valid), 32'd0);

    // FIFO empty for 10 cycles mid-query
    fifo_q.push_back(32'h14); fifo_q.push_back(32'd5);
    sb.push_back('{minval: 16'd0, pos: 32'd2, qid: 32'h14});
    do_start(1'b0, 32'd0, 16'd2);
    repeat (10) @(negedge clk);
    check("stall_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 fifo_q.push_back(32'd3);
    wait_idle("stall", 200);

    // Abort during a query keeps the reference
    fifo_q.push_back(32'h55); fifo_q.push_back(32'd5);
    do_start(1'b0, 32'd0, 16'd2);
    repeat (12) @(negedge clk);
    do_abort();
    check("abort_qry_busy", 32'(busy), 32'd0);
    check("abort_qry_ref_valid", 32'(ref_valid), 32'd1);
    repeat (5) @(negedge clk);

    // Saturation with 16-bit accumulator
    fifo_q.push_back(32'h7FFF); fifo_q.push_back(32'h7FFF);
    do_start(1'b1, 32'd2, 16'd0);
    wait_idle("load_sat", 50);
    query(32'h77, 16'd2, 32'h8000, 32'h8000, 16'hFFFF, 32'd0);

    // Reset mid-load
    fifo_q.push_back(32'd9);
    do_start(1'b1, 32'd2, 16'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    fifo_q.delete();
    @(negedge clk);
    check("midrst_ref_valid", 32'(ref_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_error", 32'(error), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
